uart_tx: RTL

//   UART transmitter: serialises one 8-bit byte per frame onto the tx line (LSB first).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 45 ++++
 rtl/uart_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART frame constants and state naming shared by the transmit and receive sides
package uart_pkg;

    localparam int   DATA_W    = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity makes the total count of ones (data + parity) even;
    // odd parity is its complement.
    function automatic logic parity_bit(input logic [DATA_W-1:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit tick counter for the UART serialiser
//
// Ports:
//   baud_tx     in   oversampled baud clock
//   reset       in   asynchronous active-low reset
//   en          in   count ticks while high
//   clr         in   hold the counter at zero (wins over en)
//   bit_end     out  high during the final tick of the current bit
//   bit_pre_end out  high during the tick just before the final one
module uart_bit_timer #(
    parameter int TICKS_PER_BIT = 9
) (
    input  logic baud_tx,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CNT_W = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(TICKS_PER_BIT - 2);

    logic [CNT_W-1:0] tick_cnt;

    always_ff @(posedge baud_tx or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (en) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    assign bit_end     = en && (tick_cnt == TICK_LAST);
    // Lets the owner register a pulse that lands exactly on the final tick.
    assign bit_pre_end = en && (tick_cnt == TICK_PRE);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: one byte per frame, LSB first, optional parity, 1 or 2 stop bits
//
// Ports:
//   baud_tx   in   oversampled baud clock, all logic on posedge
//   reset     in   asynchronous active-low reset
//   data_tx   in   byte to send, latched on accept
//   tx_valid  in   host offers a byte on data_tx
//   tx_ready  out  block accepts a byte this cycle
//   tx        out  serial line, idle high
//   tx_busy   out  frame in progress (start bit through last stop bit)
//   tx_done   out  one-cycle pulse on the final tick of the last stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = 9,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic              baud_tx,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_tx,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic [2:0] BIT_LAST  = 3'(DATA_W - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    uart_state_e       state_q, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [2:0]        bit_cnt_q, bit_cnt_n;
    logic              stop_cnt_q, stop_cnt_n;
    logic              par_q, par_n;
    logic              tx_n, ready_n, busy_n, done_n;
    logic              bit_end, bit_pre_end;
    logic              timer_en, timer_clr;

    // The timer idles at zero so the first tick after an accept is tick 0
    // of the start bit.
    assign timer_en  = (state_q != IDLE);
    assign timer_clr = (state_q == IDLE);

    uart_bit_timer #(
        .TICKS_PER_BIT(TICKS_PER_BIT)
    ) u_bit_timer (
        .baud_tx    (baud_tx),
        .reset      (reset),
        .en         (timer_en),
        .clr        (timer_clr),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    always_ff @(posedge baud_tx or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx         <= LINE_IDLE;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_n;
            bit_cnt_q  <= bit_cnt_n;
            stop_cnt_q <= stop_cnt_n;
            par_q      <= par_n;
            tx         <= tx_n;
            tx_ready   <= ready_n;
            tx_busy    <= busy_n;
            tx_done    <= done_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        bit_cnt_n  = bit_cnt_q;
        stop_cnt_n = stop_cnt_q;
        par_n      = par_q;
        done_n     = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_n    = START;
                    shift_n    = data_tx;
                    par_n      = parity_bit(data_tx, PARITY_ODD != 0);
                    bit_cnt_n  = '0;
                    stop_cnt_n = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_n    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_cnt_n = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                end
            end
            STOP: begin
                // Raised one tick early so the registered pulse sits on the
                // final tick of the last stop bit.
                if (bit_pre_end && (stop_cnt_q == STOP_LAST)) begin
                    done_n = 1'b1;
                end
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_n = IDLE;
                    end else begin
                        stop_cnt_n = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered line value
    // changes on the same edge as the state itself.
    always_comb begin
        tx_n = LINE_IDLE;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = LINE_IDLE;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

endmodule
